// File: rtl/cache_arb_types.sv
// Shared enumerations for the I/D cache-to-physical-memory arbiter.
package cache_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

endpackage

// File: rtl/cache_arbiter_checker.sv
// Protocol checker for the D-cache port: read and write must never be raised together.
module cache_arbiter_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_pmem_read,
  input  logic       d_pmem_write,
  output logic [7:0] fire_count
);

  logic [7:0] fire_count_r;

  // Count every clock edge on which the illegal read+write combination is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_count_r <= 8'd0;
    end else begin
      illegal_rw_a: assert (!(d_pmem_read && d_pmem_write))
        else fire_count_r <= fire_count_r + 8'd1;
    end
  end

  assign fire_count = fire_count_r;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between an I-cache and a D-cache.
// The granted side owns the port until pmem_resp; one IDLE cycle separates transactions.
module cache_arbiter
  import cache_arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_e state_r;
  arb_state_e state_next_s;
  grant_e     last_grant_r;
  grant_e     last_grant_next_s;
  logic       i_req_s;
  logic       d_req_s;

  assign i_req_s = i_pmem_read;
  assign d_req_s = d_pmem_read | d_pmem_write;

  // State and round-robin history; reset leaves D as last winner so I takes the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // Next-state: grant from IDLE, hold the grant until memory responds
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          if (last_grant_r == GRANT_D) begin
            state_next_s      = SERVE_I;
            last_grant_next_s = GRANT_I;
          end else begin
            state_next_s      = SERVE_D;
            last_grant_next_s = GRANT_D;
          end
        end else if (i_req_s) begin
          state_next_s      = SERVE_I;
          last_grant_next_s = GRANT_I;
        end else if (d_req_s) begin
          state_next_s      = SERVE_D;
          last_grant_next_s = GRANT_D;
        end else begin
          state_next_s = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SERVE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SERVE_D;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output mux: the granted side drives memory combinationally, everything else stays 0
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {ADDR_W{1'b0}};
    pmem_wdata   = {LINE_W{1'b0}};
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state_r)
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
      end
      default: begin
        pmem_read = 1'b0;
      end
    endcase
  end

  // Fill data is broadcast; each requester qualifies it with its own resp
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: reset, single/dual requests,
// round-robin, writeback-then-fill, mid-transaction reset and illegal D read+write.
module tb_cache_arbiter;
  import cache_arb_types::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [7:0]        fire_count;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_fill;

  int n_compared   = 0;
  int n_mismatched = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  cache_arbiter_checker chk (
    .clk(clk), .rst(rst),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .fire_count(fire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                          input logic [LINE_W-1:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_fill = {8{32'hDEAD_0001}};
    rst = 1'b1;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = 32'h0; d_pmem_wdata = {LINE_W{1'b0}};
    pmem_rdata = {LINE_W{1'b0}}; pmem_resp = 1'b0;

    // Reset: IDLE outputs even with a request present
    tick(); tick(); #1;
    check_eq("rst_pmem_read", pmem_read, 1'b0);
    check_eq("rst_pmem_addr", pmem_address, 32'h0);
    check_eq("rst_pmem_wdata", pmem_wdata, {LINE_W{1'b0}});
    check_eq("rst_i_resp", i_pmem_resp, 1'b0);
    check_eq("rst_last_grant", dut.last_grant_r, GRANT_D);

    // I-cache read alone, resp on the 5th serve cycle
    tick(); rst = 1'b0; i_pmem_address = 32'h0000_0100; #1;
    check_eq("s1_idle_read", pmem_read, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick(); #1;
      check_eq("s1_wait_i_resp", i_pmem_resp, 1'b0);
      if (c == 1) begin
        check_eq("s1_pmem_read", pmem_read, 1'b1);
        check_eq("s1_pmem_addr", pmem_address, 32'h0000_0100);
      end
    end
    tick(); pmem_resp = 1'b1; pmem_rdata = pat_fill; #1;
    check_eq("s1_i_resp", i_pmem_resp, 1'b1);
    check_eq("s1_d_resp", d_pmem_resp, 1'b0);
    check_eq("s1_i_rdata", i_pmem_rdata, pat_fill);
    check_eq("s1_addr_at_resp", pmem_address, 32'h0000_0100);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; #1;
    check_eq("s1_after_i_resp", i_pmem_resp, 1'b0);
    check_eq("s1_after_read", pmem_read, 1'b0);

    // Simultaneous I and D right after reset: I first, then D
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0200;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0300;
    tick(); pmem_resp = 1'b1; #1;
    check_eq("s2_first_addr", pmem_address, 32'h0000_0200);
    check_eq("s2_first_i_resp", i_pmem_resp, 1'b1);
    check_eq("s2_first_d_resp", d_pmem_resp, 1'b0);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0; #1;
    check_eq("s2_dead_cycle", pmem_read, 1'b0);
    tick(); #1;
    check_eq("s2_second_addr", pmem_address, 32'h0000_0300);
    pmem_resp = 1'b1; #1;
    check_eq("s2_second_d_resp", d_pmem_resp, 1'b1);
    check_eq("s2_second_i_resp", i_pmem_resp, 1'b0);
    check_eq("s2_d_rdata", d_pmem_rdata, pat_fill);
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0; #1;
    check_eq("s2_last_grant", dut.last_grant_r, GRANT_D);

    // Both sides continuously: grants alternate I, D, I, D
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0400;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0500;
    for (int k = 0; k < 4; k++) begin
      tick(); pmem_resp = 1'b1; #1;
      check_eq("s3_grant_addr", pmem_address,
               (k % 2 == 0) ? 32'h0000_0400 : 32'h0000_0500);
      check_eq("s3_grant_i_resp", i_pmem_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      tick(); pmem_resp = 1'b0; #1;
      check_eq("s3_gap", pmem_read, 1'b0);
    end
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;

    // D writeback, I arrives meanwhile, then D refill: I wins in between
    tick(); d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = pat_a5;
    tick(); i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0600; #1;
    check_eq("s4_wb_write", pmem_write, 1'b1);
    check_eq("s4_wb_read", pmem_read, 1'b0);
    check_eq("s4_wb_addr", pmem_address, 32'h0000_2000);
    check_eq("s4_wb_wdata", pmem_wdata, pat_a5);
    tick(); pmem_resp = 1'b1; #1;
    check_eq("s4_wb_d_resp", d_pmem_resp, 1'b1);
    tick(); pmem_resp = 1'b0; d_pmem_write = 1'b0; d_pmem_read = 1'b1;
    tick(); #1;
    check_eq("s4_i_between_addr", pmem_address, 32'h0000_0600);
    check_eq("s4_i_between_write", pmem_write, 1'b0);
    pmem_resp = 1'b1; #1;
    check_eq("s4_i_between_resp", i_pmem_resp, 1'b1);
    tick(); pmem_resp = 1'b0; i_pmem_read = 1'b0;
    tick(); #1;
    check_eq("s4_refill_addr", pmem_address, 32'h0000_2000);
    check_eq("s4_refill_read", pmem_read, 1'b1);
    check_eq("s4_refill_write", pmem_write, 1'b0);
    pmem_resp = 1'b1;
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0;

    // Reset in cycle 2 of SERVE_D, then a stray pmem_resp
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0700;
    tick(); #1;
    check_eq("s5_serve_read", pmem_read, 1'b1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; d_pmem_read = 1'b0; pmem_resp = 1'b1; #1;
    check_eq("s5_abort_read", pmem_read, 1'b0);
    check_eq("s5_abort_addr", pmem_address, 32'h0);
    check_eq("s5_stray_d_resp", d_pmem_resp, 1'b0);
    check_eq("s5_stray_i_resp", i_pmem_resp, 1'b0);
    check_eq("s5_state", dut.state_r, IDLE);
    tick(); pmem_resp = 1'b0; #1;
    check_eq("s5_still_idle", dut.state_r, IDLE);

    // Single-side back-to-back: SERVE, IDLE, SERVE
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0900;
    for (int k = 0; k < 2; k++) begin
      tick(); pmem_resp = 1'b1; #1;
      check_eq("s6_b2b_serve", pmem_read, 1'b1);
      check_eq("s6_b2b_i_resp", i_pmem_resp, 1'b1);
      tick(); pmem_resp = 1'b0; #1;
      check_eq("s6_b2b_gap", pmem_read, 1'b0);
    end
    i_pmem_read = 1'b0;

    // Illegal D read+write together
    tick(); #1;
    check_eq("s7_fire_before", fire_count, 8'd0);
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0800;
    tick(); d_pmem_write = 1'b0; pmem_resp = 1'b1; #1;
    check_eq("s7_fire_count", fire_count, 8'd1);
    check_eq("s7_d_resp", d_pmem_resp, 1'b1);
    tick(); pmem_resp = 1'b0; d_pmem_read = 1'b0; #1;
    check_eq("s7_fire_stable", fire_count, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
